// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver: FSM encoding and word slots.
package serial_word_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int N_WORDS = 4;

    localparam logic [1:0] W_A = 2'd0;
    localparam logic [1:0] W_B = 2'd1;
    localparam logic [1:0] W_C = 2'd2;
    localparam logic [1:0] W_D = 2'd3;

endpackage

// File: rtl/serial_word_receiver_reg_ser_par.sv
// Serial-in shift register. Presents the word it would hold after the current bit,
// so the caller can capture a completed word on the same edge as its last bit.
module reg_ser_par #(
    parameter int WORD_W    = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              en,
    input  logic              din,
    output logic [WORD_W-1:0] word
);

    logic [WORD_W-1:0] sr;

    always_comb begin
        if (MSB_FIRST) word = {sr[WORD_W-2:0], din};
        else           word = {din, sr[WORD_W-1:1]};
    end

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)  sr <= '0;
        else if (en) sr <= word;
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Deserialises a 4-word frame into A..D_out and hands it to the consumer with a
// valid/ack handshake; bits arriving while a frame is pending set a sticky overrun.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WORD_W    = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              rx_data,
    input  logic              rx_en,
    input  logic              ack,
    output logic [WORD_W-1:0] A_out,
    output logic [WORD_W-1:0] B_out,
    output logic [WORD_W-1:0] C_out,
    output logic [WORD_W-1:0] D_out,
    output logic [1:0]        word_idx,
    output logic              busy,
    output logic              valid,
    output logic              overrun
);

    localparam int              CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] word;
    logic              accept;
    logic              word_done;
    logic              frame_done;

    // Bits are taken in IDLE and RECV; in DONE they are dropped and only flag overrun.
    assign accept     = rx_en && (state != ST_DONE);
    assign word_done  = rx_en && (state == ST_RECV) && (bit_cnt == LAST_BIT);
    assign frame_done = word_done && (word_idx == W_D);

    reg_ser_par #(
        .WORD_W    (WORD_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (accept),
        .din   (rx_data),
        .word  (word)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (rx_en)      state_next = ST_RECV;
            ST_RECV: if (frame_done) state_next = ST_DONE;
            ST_DONE: if (ack)        state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == ST_RECV);
        valid = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bit_cnt  <= '0;
            word_idx <= W_A;
        end else if (accept) begin
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            if (word_done) word_idx <= word_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            A_out <= '0;
            B_out <= '0;
            C_out <= '0;
            D_out <= '0;
        end else if (word_done) begin
            case (word_idx)
                W_A: A_out <= word;
                W_B: B_out <= word;
                W_C: C_out <= word;
                W_D: D_out <= word;
            endcase
        end
    end

    // A bit on the ack edge wins: the overrun stays visible after the handshake.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)                  overrun <= 1'b0;
        else if (state == ST_DONE) begin
            if (rx_en)               overrun <= 1'b1;
            else if (ack)            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: an MSB-first and an LSB-first instance
// share one stimulus stream; each scenario task checks its own expectations.
module tb_serial_word_receiver;

    logic clk = 1'b0;
    logic clr_n, rx_data, rx_en, ack;

    logic [3:0] a_m, b_m, c_m, d_m;
    logic [1:0] idx_m;
    logic       busy_m, valid_m, ovr_m;

    logic [3:0] a_l, b_l, c_l, d_l;
    logic [1:0] idx_l;
    logic       busy_l, valid_l, ovr_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_word_receiver #(.WORD_W(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .clr_n(clr_n), .rx_data(rx_data), .rx_en(rx_en), .ack(ack),
        .A_out(a_m), .B_out(b_m), .C_out(c_m), .D_out(d_m),
        .word_idx(idx_m), .busy(busy_m), .valid(valid_m), .overrun(ovr_m)
    );

    serial_word_receiver #(.WORD_W(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .clr_n(clr_n), .rx_data(rx_data), .rx_en(rx_en), .ack(ack),
        .A_out(a_l), .B_out(b_l), .C_out(c_l), .D_out(d_l),
        .word_idx(idx_l), .busy(busy_l), .valid(valid_l), .overrun(ovr_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rx_en   = 1'b0;
        rx_data = 1'b0;
        ack     = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
    endtask

    // Streams a whole 16-bit frame MSB of the vector first, with no gaps.
    task automatic send_frame(input logic [15:0] frame);
        for (int i = 0; i < 16; i++) begin
            rx_en   = 1'b1;
            rx_data = frame[15-i];
            tick();
        end
        rx_en = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        clr_n = 1'b0;
        #12;
        checks++;
        if ({a_m, b_m, c_m, d_m, idx_m, busy_m, valid_m, ovr_m} !== 21'd0) begin
            errors++;
            $display("FAIL reset_msb got %h want 0", {a_m, b_m, c_m, d_m, idx_m, busy_m, valid_m, ovr_m});
        end
        checks++;
        if ({a_l, b_l, c_l, d_l, idx_l, busy_l, valid_l, ovr_l} !== 21'd0) begin
            errors++;
            $display("FAIL reset_lsb got %h want 0", {a_l, b_l, c_l, d_l, idx_l, busy_l, valid_l, ovr_l});
        end
        tick();
        clr_n = 1'b1;
    endtask

    task automatic test_frame();
        logic [15:0] frame;
        frame = 16'hA5F3;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            rx_en   = 1'b1;
            rx_data = frame[15-i];
            tick();
            if (i == 14) begin
                checks++;
                if ({busy_m, valid_m} !== 2'b10) begin
                    errors++;
                    $display("FAIL frame_bit15_busy_valid got %b want 10", {busy_m, valid_m});
                end
            end
        end
        rx_en = 1'b0;
        checks++;
        if ({busy_m, valid_m} !== 2'b01) begin
            errors++;
            $display("FAIL frame_done_busy_valid got %b want 01", {busy_m, valid_m});
        end
        checks++;
        if ({a_m, b_m, c_m, d_m} !== 16'hA5F3) begin
            errors++;
            $display("FAIL frame_words got %h want a5f3", {a_m, b_m, c_m, d_m});
        end
        checks++;
        if ({idx_m, ovr_m} !== 3'b000) begin
            errors++;
            $display("FAIL frame_idx_ovr got %b want 000", {idx_m, ovr_m});
        end
    endtask

    task automatic test_ack_hold();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid_m !== 1'b1) begin
                errors++;
                $display("FAIL ack_hold_valid cycle %0d got %b want 1", i, valid_m);
            end
        end
        pulse_ack();
        checks++;
        if ({busy_m, valid_m} !== 2'b00) begin
            errors++;
            $display("FAIL ack_release got %b want 00", {busy_m, valid_m});
        end
        checks++;
        if ({a_m, b_m, c_m, d_m} !== 16'hA5F3) begin
            errors++;
            $display("FAIL ack_words_held got %h want a5f3", {a_m, b_m, c_m, d_m});
        end
    endtask

    task automatic test_pauses();
        logic [15:0] frame;
        logic [1:0]  exp_idx;
        frame = 16'hA5F3;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            rx_en   = 1'b1;
            rx_data = frame[15-i];
            tick();
            if (i == 5 || i == 12) begin
                exp_idx = (i == 5) ? 2'd1 : 2'd3;
                rx_en   = 1'b0;
                for (int p = 0; p < 3; p++) begin
                    tick();
                    checks++;
                    if ({idx_m, busy_m, valid_m} !== {exp_idx, 2'b10}) begin
                        errors++;
                        $display("FAIL pause_hold bit %0d got %b want %b", i + 1,
                                 {idx_m, busy_m, valid_m}, {exp_idx, 2'b10});
                    end
                end
            end
            if (i == 14) begin
                checks++;
                if (valid_m !== 1'b0) begin
                    errors++;
                    $display("FAIL pause_early_valid got %b want 0", valid_m);
                end
            end
        end
        rx_en = 1'b0;
        checks++;
        if ({a_m, b_m, c_m, d_m, valid_m} !== {16'hA5F3, 1'b1}) begin
            errors++;
            $display("FAIL pause_frame got %h want %h", {a_m, b_m, c_m, d_m, valid_m}, {16'hA5F3, 1'b1});
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 2; i++) begin
            rx_en   = 1'b1;
            rx_data = 1'b1;
            tick();
        end
        idle_inputs();
        checks++;
        if ({ovr_m, valid_m, idx_m} !== 4'b1100) begin
            errors++;
            $display("FAIL ovr_set got %b want 1100", {ovr_m, valid_m, idx_m});
        end
        checks++;
        if ({a_m, b_m, c_m, d_m} !== 16'hA5F3) begin
            errors++;
            $display("FAIL ovr_words_held got %h want a5f3", {a_m, b_m, c_m, d_m});
        end
        pulse_ack();
        checks++;
        if ({ovr_m, valid_m} !== 2'b00) begin
            errors++;
            $display("FAIL ovr_clear_on_ack got %b want 00", {ovr_m, valid_m});
        end
        send_frame(16'h1248);
        checks++;
        if ({a_m, b_m, c_m, d_m, valid_m} !== {16'h1248, 1'b1}) begin
            errors++;
            $display("FAIL ovr_new_frame got %h want %h", {a_m, b_m, c_m, d_m, valid_m}, {16'h1248, 1'b1});
        end
        ack     = 1'b1;
        rx_en   = 1'b1;
        rx_data = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if ({busy_m, valid_m, ovr_m, idx_m} !== 5'b00100) begin
            errors++;
            $display("FAIL ack_with_bit got %b want 00100", {busy_m, valid_m, ovr_m, idx_m});
        end
        checks++;
        if ({a_m, b_m, c_m, d_m} !== 16'h1248) begin
            errors++;
            $display("FAIL ack_with_bit_words got %h want 1248", {a_m, b_m, c_m, d_m});
        end
        pulse_ack();
        checks++;
        if ({busy_m, valid_m, ovr_m} !== 3'b001) begin
            errors++;
            $display("FAIL idle_ack_ignored got %b want 001", {busy_m, valid_m, ovr_m});
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] frame;
        frame = 16'hA5F3;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            rx_en   = 1'b1;
            rx_data = frame[15-i];
            tick();
        end
        rx_en = 1'b0;
        checks++;
        if ({a_m, b_m, idx_m, busy_m} !== {8'hA5, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL midframe_pre got %h want %h", {a_m, b_m, idx_m, busy_m}, {8'hA5, 2'd2, 1'b1});
        end
        #2;
        clr_n = 1'b0;
        #1;
        checks++;
        if ({a_m, b_m, c_m, d_m, idx_m, busy_m, valid_m, ovr_m} !== 21'd0) begin
            errors++;
            $display("FAIL async_clear got %h want 0", {a_m, b_m, c_m, d_m, idx_m, busy_m, valid_m, ovr_m});
        end
        #3;
        clr_n = 1'b1;
        send_frame(16'h3C96);
        checks++;
        if ({a_m, b_m, c_m, d_m, valid_m} !== {16'h3C96, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_frame got %h want %h", {a_m, b_m, c_m, d_m, valid_m}, {16'h3C96, 1'b1});
        end
        // Each nibble arrives MSB first, so the LSB-first instance sees it bit-reversed.
        checks++;
        if ({a_l, b_l, c_l, d_l, valid_l} !== {16'hC396, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_frame_lsb got %h want %h", {a_l, b_l, c_l, d_l, valid_l}, {16'hC396, 1'b1});
        end
        pulse_ack();
    endtask

    task automatic test_bit_order();
        logic [3:0] bits;
        bits = 4'b1000;
        apply_reset();
        for (int i = 3; i >= 0; i--) begin
            rx_en   = 1'b1;
            rx_data = bits[i];
            tick();
        end
        rx_en = 1'b0;
        checks++;
        if ({a_m, idx_m} !== {4'h8, 2'd1}) begin
            errors++;
            $display("FAIL order_msb_first got %h want %h", {a_m, idx_m}, {4'h8, 2'd1});
        end
        checks++;
        if ({a_l, idx_l} !== {4'h1, 2'd1}) begin
            errors++;
            $display("FAIL order_lsb_first got %h want %h", {a_l, idx_l}, {4'h1, 2'd1});
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_ack_hold();
        test_pauses();
        test_overrun();
        test_async_reset();
        test_bit_order();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
